pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the single-cycle/multi-cycle CPU.
- Holds the architectural PC and drives it to the next-PC logic, which returns the computed successor address as `next_pc`.
- Fetches each instruction from instruction memory over a req/ack handshake with variable latency.
- Presents the instruction and its PC to decode over a valid/ready handshake.
- Watches for memory timeout and halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles to wait for `imem_ack` before flagging an error; must be ≥ 2.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high reset.
- next_pc, input, 32, successor PC from the next-PC logic; derived from `pc`; stable from one cycle after `pc` changes.
- PCWre, input, 1, PC write enable from control; 0 holds the PC and refetches the same address.
- halt, input, 1, halt request from control (halt opcode decoded).
- pc, output, 32, current architectural PC.
- imem_req, output, 1, fetch request to instruction memory.
- imem_addr, output, 32, fetch address; equals `pc` with [1:0] forced to 2'b00.
- imem_ack, input, 1, memory returns data this cycle.
- imem_rdata, input, 32, instruction word, valid when `imem_ack`=1.
- instr, output, 32, registered instruction to decode.
- instr_pc, output, 32, PC of `instr`.
- instr_valid, output, 1, `instr`/`instr_pc` valid.
- instr_ready, input, 1, decode accepts this cycle.
- halted, output, 1, fetch has stopped.
- fetch_err, output, 1, sticky timeout error.

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC; instr=0; instr_pc=0; instr_valid=0; imem_req=0; halted=0; fetch_err=0.
  - Timeout counter=0; state=START.
- States: START, REQ, WAIT, HOLD, HALTED.
- START: lasts one cycle after reset release, then goes to REQ. Gives the next-PC logic one cycle to settle `next_pc`.
- REQ:
  - imem_req=1 (registered; asserted on entry).
  - If imem_ack=1 in the same cycle: capture `imem_rdata`→instr and pc→instr_pc, set instr_valid=1, clear imem_req, go to HOLD.
  - Otherwise go to WAIT.
- WAIT:
  - imem_req stays 1; counter increments each cycle.
  - On imem_ack: capture as in REQ, clear the counter, go to HOLD.
  - If the counter reaches TIMEOUT-1 without an ack: set fetch_err=1, clear imem_req, go to HALTED. An ack arriving in that same cycle is ignored.
- HOLD:
  - instr_valid=1 and instr is held stable until instr_valid & instr_ready.
  - On that handshake, instr_valid is cleared the next cycle.
  - PC update at the handshake: if PCWre=1, pc←next_pc, else pc is unchanged.
  - Next state at the handshake: if halt=1, go to HALTED; otherwise go to START (the one-cycle settle gap keeps `next_pc` valid relative to the new pc).
  - halt sampled outside the handshake cycle is ignored.
- HALTED:
  - halted=1; imem_req=0; instr_valid=0; pc frozen.
  - Only reset exits this state.
- imem_ack outside REQ/WAIT: ignored, no capture.
- Arithmetic: PC is 32-bit and wraps modulo 2^32 (0xFFFF_FFFC → next_pc as supplied, no checking). Unaligned next_pc is stored as-is; only imem_addr masks bits [1:0].
- Throughput: best case 3 cycles per instruction (START, REQ with same-cycle ack, HOLD with ready=1).
- Reset mid-WAIT: the request is dropped immediately. The memory must tolerate imem_req falling without an ack.

Test Plan:
- Reset release, ack in REQ, ready=1, PCWre=1, next_pc=pc+4 → instr_pc sequence 0x0, 0x4, 0x8, one accepted instr every 3 cycles; imem_addr matches.
- Memory ack delayed 3 cycles → imem_req high for 4 cycles; instr equals the rdata sampled at the ack; counter clears; fetch_err stays 0.
- No ack for TIMEOUT=16 cycles → fetch_err=1 and halted=1 at the 16th request cycle; a late ack has no effect; only reset clears both.
- instr_ready=0 for 5 cycles in HOLD → instr, instr_pc, pc unchanged, instr_valid held at 1; pc updates to next_pc=0x0000_0040 (jump) only at the handshake.
- PCWre=0 at the handshake → same address refetched; instr_pc repeats.
- halt=1 at the handshake → pc updates, halted=1 next cycle, imem_req stays 0.
- halt=1 while instr_valid=0 → ignored.
- Async reset asserted mid-WAIT (between clock edges) → all outputs at reset values immediately; pc=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: one fetch per instruction over a
// req/ack memory handshake, presented to decode over valid/ready, with timeout and halt.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        PCWre,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_START,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALTED
    } state_t;

    // REQ is the first request cycle, so WAIT gives up one count early to keep
    // the total request length at exactly TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_instr_pc;
    logic             r_valid;
    logic             r_req;
    logic             r_halted;
    logic             r_err;

    logic             w_accept;

    assign w_accept = r_valid & instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_START;
            r_cnt      <= '0;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_req      <= 1'b0;
            r_halted   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_START: begin
                    r_req   <= 1'b1;
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        r_instr    <= imem_rdata;
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        r_req      <= 1'b0;
                        r_state    <= S_HOLD;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Timeout wins over an ack arriving in the final cycle.
                    if (r_cnt == CNT_LAST) begin
                        r_err    <= 1'b1;
                        r_req    <= 1'b0;
                        r_halted <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_HALTED;
                    end else if (imem_ack) begin
                        r_instr    <= imem_rdata;
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        r_req      <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        if (PCWre) begin
                            r_pc <= next_pc;
                        end
                        if (halt) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALTED;
                        end else begin
                            r_state <= S_START;
                        end
                    end
                end
                S_HALTED: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_START;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign imem_req    = r_req;
    assign imem_addr   = {r_pc[31:2], 2'b00};
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign halted      = r_halted;
    assign fetch_err   = r_err;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: per-cycle vector table for the fetch/decode flow,
// plus hand-written sequences for memory timeout and asynchronous reset mid-fetch.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] next_pc;
    logic        PCWre = 1'b1;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        halted;
    logic        fetch_err;

    // Next-PC logic stand-in: sequential pc+4 unless a jump target is selected.
    logic        jen = 1'b0;
    logic [31:0] jtgt = '0;
    assign next_pc = jen ? jtgt : pc + 32'd4;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .next_pc(next_pc), .PCWre(PCWre), .halt(halt),
        .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted),
        .fetch_err(fetch_err)
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        we;
        logic        hlt;
        logic        jen;
        logic [31:0] jtgt;
        logic        e_req;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic [31:0] e_pc;
        logic        e_hlt;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] D0 = 32'h1111_0000, D1 = 32'h2222_0001, D2 = 32'h3333_0002;
    localparam logic [31:0] D3 = 32'h4444_0003, D4 = 32'h5555_0004, D5 = 32'h6666_0005;
    localparam logic [31:0] D6 = 32'h7777_0006, D7 = 32'h8888_0007, D8 = 32'h9999_0008;

    function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic rdy,
                                input logic we, input logic hlt, input logic j,
                                input logic [31:0] jt, input logic e_req, input logic e_vld,
                                input logic [31:0] e_instr, input logic [31:0] e_ipc,
                                input logic [31:0] e_pc, input logic e_hlt);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.we = we; v.hlt = hlt;
        v.jen = j; v.jtgt = jt; v.e_req = e_req; v.e_vld = e_vld; v.e_instr = e_instr;
        v.e_ipc = e_ipc; v.e_pc = e_pc; v.e_hlt = e_hlt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic e_vld,
                           input logic [31:0] e_instr, input logic [31:0] e_ipc,
                           input logic [31:0] e_pc, input logic e_hlt, input logic e_err);
        logic [31:0] e_addr;
        e_addr = {e_pc[31:2], 2'b00};
        chk({tag, " imem_req"},    {31'd0, imem_req},    {31'd0, e_req});
        chk({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, e_vld});
        chk({tag, " instr"},       instr,                e_instr);
        chk({tag, " instr_pc"},    instr_pc,             e_ipc);
        chk({tag, " pc"},          pc,                   e_pc);
        chk({tag, " imem_addr"},   imem_addr,            e_addr);
        chk({tag, " halted"},      {31'd0, halted},      {31'd0, e_hlt});
        chk({tag, " fetch_err"},   {31'd0, fetch_err},   {31'd0, e_err});
    endtask

    task automatic idle_inputs();
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        PCWre = 1'b1; halt = 1'b0; jen = 1'b0; jtgt = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset across one edge, checks the reset state, releases off-edge.
    task automatic do_reset(input string tag);
        idle_inputs();
        reset = 1'b1;
        step();
        chk_all({tag, " reset"}, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        // Row i: inputs during cycle i, expected outputs right after its closing edge.
        //            ack rdata         rdy we hlt jen jtgt         req vld instr ipc           pc            hlt
        tbl.push_back(mk(1, 32'hDEAD_BEEF, 0, 1, 0, 0, 0,            1, 0, 32'h0, 32'h0,        32'h0,        0)); // START ignores ack
        tbl.push_back(mk(1, D0,          0, 1, 0, 0, 0,            0, 1, D0,    32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 0,           1, 1, 0, 0, 0,            0, 0, D0,    32'h0,        32'h4,        0));
        tbl.push_back(mk(0, 0,           0, 1, 1, 0, 0,            1, 0, D0,    32'h0,        32'h4,        0)); // halt w/o valid
        tbl.push_back(mk(1, D1,          0, 1, 0, 0, 0,            0, 1, D1,    32'h4,        32'h4,        0));
        tbl.push_back(mk(0, 0,           1, 1, 0, 0, 0,            0, 0, D1,    32'h4,        32'h8,        0));
        tbl.push_back(mk(0, 0,           0, 1, 0, 0, 0,            1, 0, D1,    32'h4,        32'h8,        0));
        tbl.push_back(mk(1, D2,          0, 1, 0, 0, 0,            0, 1, D2,    32'h8,        32'h8,        0));
        tbl.push_back(mk(0, 0,           1, 1, 0, 0, 0,            0, 0, D2,    32'h8,        32'hC,        0));
        tbl.push_back(mk(0, 0,           0, 1, 0, 0, 0,            1, 0, D2,    32'h8,        32'hC,        0));
        tbl.push_back(mk(0, 0,           0, 1, 0, 0, 0,            1, 0, D2,    32'h8,        32'hC,        0)); // delayed ack
        tbl.push_back(mk(0, 0,           0, 1, 0, 0, 0,            1, 0, D2,    32'h8,        32'hC,        0));
        tbl.push_back(mk(0, 0,           0, 1, 0, 0, 0,            1, 0, D2,    32'h8,        32'hC,        0));
        tbl.push_back(mk(1, D3,          0, 1, 0, 0, 0,            0, 1, D3,    32'hC,        32'hC,        0));
        tbl.push_back(mk(0, 0,           0, 1, 0, 1, 32'h40,       0, 1, D3,    32'hC,        32'hC,        0)); // stall
        tbl.push_back(mk(0, 0,           0, 1, 1, 1, 32'h40,       0, 1, D3,    32'hC,        32'hC,        0));
        tbl.push_back(mk(1, D8,          0, 1, 0, 1, 32'h40,       0, 1, D3,    32'hC,        32'hC,        0));
        tbl.push_back(mk(0, 0,           0, 1, 0, 1, 32'h40,       0, 1, D3,    32'hC,        32'hC,        0));
        tbl.push_back(mk(0, 0,           0, 1, 0, 1, 32'h40,       0, 1, D3,    32'hC,        32'hC,        0));
        tbl.push_back(mk(0, 0,           1, 1, 0, 1, 32'h40,       0, 0, D3,    32'hC,        32'h40,       0)); // jump
        tbl.push_back(mk(0, 0,           0, 1, 0, 0, 0,            1, 0, D3,    32'hC,        32'h40,       0));
        tbl.push_back(mk(1, D4,          0, 1, 0, 0, 0,            0, 1, D4,    32'h40,       32'h40,       0));
        tbl.push_back(mk(0, 0,           1, 0, 0, 1, 32'h80,       0, 0, D4,    32'h40,       32'h40,       0)); // PCWre=0
        tbl.push_back(mk(0, 0,           0, 1, 0, 0, 0,            1, 0, D4,    32'h40,       32'h40,       0));
        tbl.push_back(mk(1, D5,          0, 1, 0, 0, 0,            0, 1, D5,    32'h40,       32'h40,       0));
        tbl.push_back(mk(0, 0,           1, 1, 0, 1, 32'h43,       0, 0, D5,    32'h40,       32'h43,       0)); // unaligned
        tbl.push_back(mk(0, 0,           0, 1, 0, 0, 0,            1, 0, D5,    32'h40,       32'h43,       0));
        tbl.push_back(mk(1, D6,          0, 1, 0, 0, 0,            0, 1, D6,    32'h43,       32'h43,       0));
        tbl.push_back(mk(0, 0,           1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, D6,   32'h43,       32'hFFFF_FFFC, 0));
        tbl.push_back(mk(0, 0,           0, 1, 0, 0, 0,            1, 0, D6,    32'h43,       32'hFFFF_FFFC, 0));
        tbl.push_back(mk(1, D7,          0, 1, 0, 0, 0,            0, 1, D7,    32'hFFFF_FFFC, 32'hFFFF_FFFC, 0));
        tbl.push_back(mk(0, 0,           1, 1, 0, 0, 0,            0, 0, D7,    32'hFFFF_FFFC, 32'h0,        0)); // wrap
        tbl.push_back(mk(0, 0,           0, 1, 0, 0, 0,            1, 0, D7,    32'hFFFF_FFFC, 32'h0,        0));
        tbl.push_back(mk(1, D8,          0, 1, 0, 0, 0,            0, 1, D8,    32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 0,           1, 1, 1, 0, 0,            0, 0, D8,    32'h0,        32'h4,        1)); // halt
        tbl.push_back(mk(1, D0,          1, 1, 0, 0, 0,            0, 0, D8,    32'h0,        32'h4,        1));
        tbl.push_back(mk(1, D1,          1, 1, 1, 0, 0,            0, 0, D8,    32'h0,        32'h4,        1));

        do_reset("tbl");
        foreach (tbl[i]) begin
            imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata; instr_ready = tbl[i].rdy;
            PCWre = tbl[i].we; halt = tbl[i].hlt; jen = tbl[i].jen; jtgt = tbl[i].jtgt;
            step();
            chk_all($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_vld, tbl[i].e_instr,
                    tbl[i].e_ipc, tbl[i].e_pc, tbl[i].e_hlt, 1'b0);
        end

        // Timeout: no ack for 16 request cycles; an ack in the 16th is too late.
        do_reset("tmo");
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("tmo cyc%0d req", k), {30'd0, imem_req, fetch_err}, 32'h2);
            if (k == 15) begin
                imem_ack = 1'b1;
                imem_rdata = D5;
            end
        end
        step();
        chk_all("tmo expire", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        instr_ready = 1'b1;
        step();
        step();
        chk_all("tmo late ack", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);

        // Async reset between edges while a request is outstanding.
        do_reset("arst");
        step();                                    // START -> REQ
        imem_ack = 1'b1; imem_rdata = D2;
        step();                                    // REQ ack -> HOLD
        imem_ack = 1'b0; instr_ready = 1'b1; jen = 1'b1; jtgt = 32'h100;
        step();                                    // handshake, pc=0x100
        instr_ready = 1'b0; jen = 1'b0;
        step();                                    // START -> REQ
        step();                                    // REQ no ack -> WAIT
        step();                                    // WAIT
        chk_all("arst pre", 1'b1, 1'b0, D2, 32'h0, 32'h100, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("arst now", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk_all("arst restart", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
